lfsr_bit_collector: RTL and testbench
=====================================

Name: lfsr_bit_collector

Overview:
Downstream consumer of the LFSR serial output stage. Samples the registered serial bit stream (OUT qualified by Valid), reassembles LSB-first words of WIDTH bits and buffers completed words in a small synchronous FIFO. A downstream reader pops the words with a registered read handshake. Provides fill level, a sticky overflow flag and a partial-word flush.

Parameters:
WIDTH, 8, bits per reassembled word; matches the LFSR register width.
DEPTH, 4, FIFO entries; must be a power of two and at least 2.
AW, 2, FIFO address width; equals log2(DEPTH).

Ports:
clock  input  1  single system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately.
bit_in  input  1  serial data bit; connects to the LFSR OUT output.
bit_valid  input  1  bit_in qualifier; connects to the LFSR Valid output.
flush  input  1  discard the partially assembled word.
clear_ovf  input  1  clear the sticky overflow flag.
rd_en  input  1  pop request from the downstream reader.
data_out  output  WIDTH  popped word, registered.
data_valid  output  1  one-cycle pulse marking data_out as newly popped.
fifo_empty  output  1  FIFO holds 0 words.
fifo_full  output  1  FIFO holds DEPTH words.
fill_level  output  AW+1  number of words held, 0 to DEPTH.
bit_count  output  $clog2(WIDTH)  bits collected in the current partial word.
overflow  output  1  sticky; a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): shift register, bit_count, FIFO pointers, data_out, data_valid and overflow all go to 0. fifo_empty=1, fifo_full=0, fill_level=0. FIFO contents are don't-care. A reset asserted mid-word or mid-read discards everything.
- Bit assembly (LSB first):
  - The first accepted bit becomes bit 0 of the word, matching the LFSR's right-shift output order.
  - On each cycle with bit_valid=1 and flush=0: shift_reg <= {bit_in, shift_reg[WIDTH-1:1]} and bit_count increments.
  - When bit_valid=1 and bit_count==WIDTH-1, the word is complete. The completed word is {bit_in, shift_reg[WIDTH-1:1]}. bit_count wraps to 0 and a push is requested in the same cycle.
  - bit_valid=0 holds shift_reg and bit_count; gaps between bits are allowed.
- flush: when asserted, bit_count <= 0 and shift_reg <= 0. flush has priority over bit_valid in the same cycle, so that bit is discarded and no push occurs. flush does not touch the FIFO or overflow.
- FIFO write:
  - The push is written at wr_ptr in the same edge as word completion, so the word is visible in fill_level on the next cycle.
  - If the FIFO is full and no pop occurs in that cycle, the word is dropped and overflow <= 1.
- FIFO read:
  - rd_en=1 with fifo_empty=0 pops at rd_ptr. data_out is loaded and data_valid=1 on the following cycle, giving a 1-cycle latency.
  - rd_en with fifo_empty=1 is ignored and data_valid stays 0.
  - data_out holds its last value between pops. data_valid is 0 on every cycle without a pop.
- Simultaneous push and pop:
  - Not full and not empty: both occur and fill_level is unchanged.
  - Full: the pop frees a slot, the push is accepted and overflow is not set.
  - Empty: no fall-through. The push is accepted, the pop is ignored and fill_level becomes 1.
- Pointers are AW bits and wrap modulo DEPTH. fill_level is a separate counter; fifo_full and fifo_empty are decoded from fill_level.
- overflow: set by a dropped word and cleared by clear_ovf. If both occur in the same cycle, set wins.
- The outputs fifo_empty, fifo_full, fill_level, bit_count and overflow are registered state or direct decodes of it. There is no combinational path from inputs to outputs.

Test Plan:
- Reset then bits 0,1,0,1,0,1,0,1 (first to last) with bit_valid=1, then rd_en -> fill_level=1; data_out=8'hAA with data_valid=1 exactly one cycle after rd_en; fifo_empty=1 afterwards.
- Bits with bit_valid gaps (1 on cycles 0,3,4,7,8,10,12,15; bits all 1) -> exactly one push, word 8'hFF, bit_count returns to 0.
- Three bits, then flush asserted together with bit_valid, then 8 bits 1,0,0,0,0,0,0,0 -> single word 8'h01; no word contains pre-flush bits.
- Push 5 words (8'h11..8'h55) with DEPTH=4 and no reads -> fifo_full=1, overflow=1, word 8'h55 lost. Then 4 pops return 8'h11,8'h22,8'h33,8'h44. clear_ovf -> overflow=0.
- FIFO full, word completion and rd_en in the same cycle -> overflow stays 0, fill_level stays 4, oldest word output.
- Reset asserted mid-word (bit_count=5) and with 2 words stored -> all outputs return to reset values asynchronously; a following 8-bit word reads back correctly as the first entry.

Source files
------------

// File: rtl/lfsr_bit_collector.sv
// Purpose : reassembles an LSB-first serial bit stream into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Latency : a word is in the FIFO one edge after its last bit; a pop shows on data_out one edge after rd_en.
// Backpr. : there is none upstream. A word completed while the FIFO is full and not popping is dropped and sets overflow.
//
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-low reset
//   bit_in, bit_valid  serial data and its qualifier (LFSR OUT / Valid)
//   flush              discards the partially assembled word
//   clear_ovf          clears the sticky overflow flag
//   rd_en              pop request; ignored while the FIFO is empty
//   data_out           registered popped word
//   data_valid         one-cycle pulse for a new data_out
//   fifo_empty         FIFO status, decoded from fill_level
//   fifo_full          FIFO status, decoded from fill_level
//   fill_level         number of words held, 0..DEPTH
//   bit_count          bits collected in the current partial word
//   overflow           sticky flag: a word was dropped
module lfsr_bit_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     flush,
    input  logic                     clear_ovf,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [AW:0]              fill_level,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic accept_bit;
    logic word_done;
    logic pop;
    logic push;
    logic drop;

    // A new bit enters at the MSB, so after WIDTH shifts the first bit sits at bit 0.
    assign shift_nxt  = {bit_in, shift_reg[WIDTH-1:1]};
    assign accept_bit = bit_valid && !flush;
    assign word_done  = accept_bit && (bit_count == LAST_BIT);

    assign fifo_empty = (fill_level == '0);
    assign fifo_full  = (fill_level == FULL_LVL);

    // The pop is decided on the current level, so an empty FIFO never falls through a same-cycle push.
    // A pop from a full FIFO frees the slot that a same-cycle push then takes.
    assign pop  = rd_en && !fifo_empty;
    assign push = word_done && (!fifo_full || pop);
    assign drop = word_done && fifo_full && !pop;

    // Bit assembly
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (flush) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (bit_valid) begin
            shift_reg <= shift_nxt;
            bit_count <= word_done ? '0 : bit_count + 1'b1;
        end
    end

    // FIFO storage has no reset because its contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= shift_nxt;
        end
    end

    // FIFO pointers, level, read port and overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            data_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            // A drop in the same cycle as clear_ovf leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_bit_collector.sv
module tb_lfsr_bit_collector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       flush = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] fill_level;
    logic [2:0] bit_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain list of pending bits and a queue of words.
    int         m_bits[$];
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0;

    lfsr_bit_collector #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .clear_ovf  (clear_ovf),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fill_level (fill_level),
        .bit_count  (bit_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_bits.delete();
        m_q.delete();
        m_ovf  = 1'b0;
        m_dout = 8'h00;
        m_dv   = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic bv, input logic fl,
                              input logic co, input logic rd);
        logic       have_word;
        logic       do_pop;
        logic [7:0] w;
        have_word = 1'b0;
        w = 8'h00;
        do_pop = rd && (m_q.size() > 0);
        if (fl) begin
            m_bits.delete();
        end else if (bv) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) w = w + 8'(m_bits[i] << i);
                m_bits.delete();
                have_word = 1'b1;
            end
        end
        if (co) m_ovf = 1'b0;
        if (do_pop) begin
            m_dout = m_q.pop_front();
            m_dv   = 1'b1;
        end else begin
            m_dv = 1'b0;
        end
        if (have_word) begin
            if (m_q.size() < 4) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    // Drives one cycle. Inputs change at a falling edge, and the task returns at the
    // next falling edge, so the outputs it leaves behind reflect that cycle's update.
    task automatic cyc(input logic b, input logic bv, input logic fl,
                       input logic co, input logic rd);
        bit_in = b; bit_valid = bv; flush = fl; clear_ovf = co; rd_en = rd;
        model_step(b, bv, fl, co, rd);
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) cyc(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; clear_ovf = 1'b0; rd_en = 1'b0;
        reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({fifo_empty, fifo_full, fill_level, bit_count, overflow, data_valid, data_out}
            !== {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_state: empty=%b full=%b lvl=%0d bc=%0d ovf=%b dv=%b dout=%h, need 1 0 0 0 0 0 00",
                     fifo_empty, fifo_full, fill_level, bit_count, overflow, data_valid, data_out);
        end
        release_reset();
    endtask

    task automatic test_basic_word();
        logic [7:0] pat;
        pat = 8'b1010_1010;
        for (int i = 0; i < 8; i++) cyc(pat[i], 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (fill_level !== 3'd1) begin
            fails++;
            $display("FAIL basic_fill: got %0d need 1", fill_level);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b1 || data_out !== 8'hAA) begin
            fails++;
            $display("FAIL basic_pop: dv=%b dout=%h need 1 aa", data_valid, data_out);
        end
        tests++;
        if (fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL basic_empty: got %b need 1", fifo_empty);
        end
        idle();
        tests++;
        if (data_valid !== 1'b0 || data_out !== 8'hAA) begin
            fails++;
            $display("FAIL basic_hold: dv=%b dout=%h need 0 aa", data_valid, data_out);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] vmask;
        vmask = 16'b1001_0101_1001_1001; // cycles 0,3,4,7,8,10,12,15
        for (int c = 0; c < 16; c++) begin
            cyc(1'b1, vmask[c], 1'b0, 1'b0, 1'b0);
            if (c == 12) begin
                tests++;
                if (bit_count !== 3'd7 || fill_level !== 3'd0) begin
                    fails++;
                    $display("FAIL gaps_partial: bc=%0d lvl=%0d need 7 0", bit_count, fill_level);
                end
            end
        end
        tests++;
        if (bit_count !== 3'd0 || fill_level !== 3'd1) begin
            fails++;
            $display("FAIL gaps_done: bc=%0d lvl=%0d need 0 1", bit_count, fill_level);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b1 || data_out !== 8'hFF) begin
            fails++;
            $display("FAIL gaps_word: dv=%b dout=%h need 1 ff", data_valid, data_out);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (bit_count !== 3'd0 || fill_level !== 3'd0) begin
            fails++;
            $display("FAIL flush_clear: bc=%0d lvl=%0d need 0 0", bit_count, fill_level);
        end
        send_word(8'h01);
        tests++;
        if (fill_level !== 3'd1) begin
            fails++;
            $display("FAIL flush_fill: got %0d need 1", fill_level);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b1 || data_out !== 8'h01) begin
            fails++;
            $display("FAIL flush_word: dv=%b dout=%h need 1 01", data_valid, data_out);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_word(8'(i * 8'h11));
        tests++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1 || fill_level !== 3'd4) begin
            fails++;
            $display("FAIL ovf_state: full=%b ovf=%b lvl=%0d need 1 1 4", fifo_full, overflow, fill_level);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i * 8'h11);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tests++;
            if (data_valid !== 1'b1 || data_out !== exp) begin
                fails++;
                $display("FAIL ovf_pop%0d: dv=%b dout=%h need 1 %h", i, data_valid, data_out, exp);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b0 || fifo_empty !== 1'b1 || data_out !== 8'h44) begin
            fails++;
            $display("FAIL ovf_empty_rd: dv=%b empty=%b dout=%h need 0 1 44", data_valid, fifo_empty, data_out);
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b need 1", overflow);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %b need 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] w;
        logic [7:0] exp[4];
        for (int i = 1; i <= 4; i++) send_word(8'hA0 + 8'(i));
        w = 8'hB5;
        for (int i = 0; i < 7; i++) cyc(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(w[7], 1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if (overflow !== 1'b0 || fill_level !== 3'd4 || data_valid !== 1'b1 || data_out !== 8'hA1) begin
            fails++;
            $display("FAIL full_pushpop: ovf=%b lvl=%0d dv=%b dout=%h need 0 4 1 a1",
                     overflow, fill_level, data_valid, data_out);
        end
        exp = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tests++;
            if (data_valid !== 1'b1 || data_out !== exp[i]) begin
                fails++;
                $display("FAIL full_drain%0d: dv=%b dout=%h need 1 %h", i, data_valid, data_out, exp[i]);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        logic [7:0] w;
        w = 8'h3C;
        for (int i = 0; i < 7; i++) cyc(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(w[7], 1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b0 || fill_level !== 3'd1) begin
            fails++;
            $display("FAIL empty_pushpop: dv=%b lvl=%0d need 0 1", data_valid, fill_level);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
            fails++;
            $display("FAIL empty_pushpop_word: dv=%b dout=%h need 1 3c", data_valid, data_out);
        end
    endtask

    task automatic test_reset_mid();
        send_word(8'h12);
        send_word(8'h34);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bit_count !== 3'd5 || fill_level !== 3'd2) begin
            fails++;
            $display("FAIL mid_setup: bc=%0d lvl=%0d need 5 2", bit_count, fill_level);
        end
        apply_reset();
        tests++;
        if ({fifo_empty, fifo_full, fill_level, bit_count, overflow, data_valid, data_out}
            !== {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL mid_async_reset: empty=%b full=%b lvl=%0d bc=%0d ovf=%b dv=%b dout=%h",
                     fifo_empty, fifo_full, fill_level, bit_count, overflow, data_valid, data_out);
        end
        release_reset();
        send_word(8'h5A);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (data_valid !== 1'b1 || data_out !== 8'h5A || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL mid_after: dv=%b dout=%h empty=%b need 1 5a 1", data_valid, data_out, fifo_empty);
        end
    endtask

    task automatic test_random();
        int rd_pct;
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            rd_pct = (c < 300) ? 8 : 45;
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 65),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 99) < rd_pct));
            tests++;
            if (fill_level !== 3'(m_q.size()) || bit_count !== 3'(m_bits.size()) ||
                overflow !== m_ovf || data_valid !== m_dv || data_out !== m_dout ||
                fifo_empty !== (m_q.size() == 0) || fifo_full !== (m_q.size() == 4)) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_c%0d: lvl=%0d bc=%0d ovf=%b dv=%b dout=%h, need lvl=%0d bc=%0d ovf=%b dv=%b dout=%h",
                             c, fill_level, bit_count, overflow, data_valid, data_out,
                             m_q.size(), m_bits.size(), m_ovf, m_dv, m_dout);
            end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic_word();
        test_gaps();
        test_flush();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
